// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, EX/MEM handshake states and the
// read-data substitute used when a memory access is abandoned.
package cpu_pkg;

    localparam int WB_W       = 23;
    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 4;

    localparam logic [WORD_W-1:0] MEM_ERR_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } exmem_state_t;

    // A read+write combination is illegal and resolved as a read elsewhere,
    // but it is still a memory op.
    function automatic logic is_mem_op(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/exmem_stage_if.sv
// Shared-memory request/acknowledge bus between the EX/MEM register (master)
// and the memory arbiter (slave).
interface exmem_stage_if;

    logic                       mem_req;
    logic                       mem_we;
    logic [cpu_pkg::WORD_W-1:0] mem_addr;
    logic [cpu_pkg::WORD_W-1:0] mem_wdata;
    logic [cpu_pkg::WORD_W-1:0] mem_rdata;
    logic                       mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_handshake_fsm.sv
// Handshake controller for the EX/MEM register: tracks the outstanding access,
// counts unacknowledged cycles and tells the register file when to load.
module mem_handshake_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_stall_in,
    input  logic         i_clear,
    input  logic         i_memop,
    input  logic         i_mem_ack,
    output exmem_state_t o_state,
    output logic         o_capture_en,
    output logic         o_ack_latch,
    output logic         o_timeout_latch,
    output logic         o_mem_timeout
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    exmem_state_t     r_state;
    exmem_state_t     w_state_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic             r_timeout;
    logic             w_expire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_timeout  <= w_expire;
        end
    end

    // Ack wins over expiry when both land in the last allowed cycle.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_expire        = 1'b0;
        case (r_state)
            ACCESS: begin
                if (i_mem_ack) begin
                    w_state_next    = DONE;
                    w_wait_cnt_next = '0;
                end else if (r_wait_cnt == CNT_LAST) begin
                    w_state_next    = DONE;
                    w_wait_cnt_next = '0;
                    w_expire        = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                if (!i_stall_in)
                    w_state_next = (!i_clear && i_memop) ? ACCESS : IDLE;
            end
        endcase
    end

    always_comb begin
        o_state         = r_state;
        o_capture_en    = (r_state != ACCESS) && !i_stall_in;
        o_ack_latch     = (r_state == ACCESS) && i_mem_ack;
        o_timeout_latch = w_expire;
        o_mem_timeout   = r_timeout;
    end

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register: captures the EX results, runs the shared-memory
// handshake for loads/stores and stalls upstream while an access is open.
module exmem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WB_W-1:0]       wb,
    input  logic [WORD_W-1:0]     alu_result,
    input  logic [WORD_W-1:0]     store_data,
    input  logic [REG_ADDR_W-1:0] dest_addr,
    input  logic                  hazard_ar,
    input  logic                  hazard_mem,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic                  clear,
    input  logic                  stall_in,
    exmem_stage_if.master         mem,
    output logic                  stall_out,
    output logic [WB_W-1:0]       wbreg,
    output logic [WORD_W-1:0]     resultreg,
    output logic [REG_ADDR_W-1:0] destreg,
    output logic                  hazard_arreg,
    output logic                  hazard_memreg,
    output logic                  mem_timeout
);

    exmem_state_t          w_state;
    logic                  w_capture_en;
    logic                  w_ack_latch;
    logic                  w_timeout_latch;
    logic                  w_access;

    logic [WB_W-1:0]       r_wb_reg;
    logic [WORD_W-1:0]     r_alu_reg;
    logic [WORD_W-1:0]     r_store_reg;
    logic [WORD_W-1:0]     r_rdata_reg;
    logic [REG_ADDR_W-1:0] r_dest_reg;
    logic                  r_hazard_ar_reg;
    logic                  r_hazard_mem_reg;
    logic                  r_memread_reg;
    logic                  r_memwrite_reg;

    mem_handshake_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk            (clk),
        .rst            (rst),
        .i_stall_in     (stall_in),
        .i_clear        (clear),
        .i_memop        (is_mem_op(memread, memwrite)),
        .i_mem_ack      (mem.mem_ack),
        .o_state        (w_state),
        .o_capture_en   (w_capture_en),
        .o_ack_latch    (w_ack_latch),
        .o_timeout_latch(w_timeout_latch),
        .o_mem_timeout  (mem_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_reg         <= '0;
            r_alu_reg        <= '0;
            r_store_reg      <= '0;
            r_rdata_reg      <= '0;
            r_dest_reg       <= '0;
            r_hazard_ar_reg  <= 1'b0;
            r_hazard_mem_reg <= 1'b0;
            r_memread_reg    <= 1'b0;
            r_memwrite_reg   <= 1'b0;
        end else if (w_capture_en) begin
            r_rdata_reg <= '0;
            if (clear) begin
                r_wb_reg         <= '0;
                r_alu_reg        <= '0;
                r_store_reg      <= '0;
                r_dest_reg       <= '0;
                r_hazard_ar_reg  <= 1'b0;
                r_hazard_mem_reg <= 1'b0;
                r_memread_reg    <= 1'b0;
                r_memwrite_reg   <= 1'b0;
            end else begin
                r_wb_reg         <= wb;
                r_alu_reg        <= alu_result;
                r_store_reg      <= store_data;
                r_dest_reg       <= dest_addr;
                r_hazard_ar_reg  <= hazard_ar;
                r_hazard_mem_reg <= hazard_mem;
                r_memread_reg    <= memread;
                // read+write is resolved as a plain read
                r_memwrite_reg   <= memwrite & ~memread;
            end
        end else begin
            if (w_ack_latch && r_memread_reg)
                r_rdata_reg <= mem.mem_rdata;
            // an abandoned access must not retire a write-back
            if (w_timeout_latch) begin
                r_rdata_reg <= MEM_ERR_DATA;
                r_wb_reg    <= '0;
            end
        end
    end

    assign w_access      = (w_state == ACCESS);
    assign stall_out     = w_access;
    assign mem.mem_req   = w_access;
    assign mem.mem_we    = w_access & r_memwrite_reg;
    assign mem.mem_addr  = w_access ? r_alu_reg   : '0;
    assign mem.mem_wdata = w_access ? r_store_reg : '0;

    assign wbreg         = r_wb_reg;
    assign resultreg     = r_memread_reg ? r_rdata_reg : r_alu_reg;
    assign destreg       = r_dest_reg;
    assign hazard_arreg  = r_hazard_ar_reg;
    assign hazard_memreg = r_hazard_mem_reg;

endmodule

// File: tb/tb_exmem_stage.sv
// Directed bench for exmem_stage: vector table for non-memory captures plus
// hand-written load/store/timeout/clear/reset sequences (TIMEOUT = 4).
module tb_exmem_stage;

    logic        clk;
    logic        rst;
    logic [22:0] wb;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic [3:0]  dest_addr;
    logic        hazard_ar, hazard_mem, memread, memwrite, clear, stall_in;
    logic        stall_out;
    logic [22:0] wbreg;
    logic [15:0] resultreg;
    logic [3:0]  destreg;
    logic        hazard_arreg, hazard_memreg, mem_timeout;

    exmem_stage_if mem_bus ();

    exmem_stage #(
        .TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb           (wb),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .dest_addr    (dest_addr),
        .hazard_ar    (hazard_ar),
        .hazard_mem   (hazard_mem),
        .memread      (memread),
        .memwrite     (memwrite),
        .clear        (clear),
        .stall_in     (stall_in),
        .mem          (mem_bus),
        .stall_out    (stall_out),
        .wbreg        (wbreg),
        .resultreg    (resultreg),
        .destreg      (destreg),
        .hazard_arreg (hazard_arreg),
        .hazard_memreg(hazard_memreg),
        .mem_timeout  (mem_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [22:0] wb;
        logic [15:0] alu;
        logic [3:0]  dest;
        logic        har, hmem, rd, clr, stl;
        logic [22:0] e_wb;
        logic [15:0] e_res;
        logic [3:0]  e_dest;
        logic        e_har, e_hmem;
    } vec_t;

    vec_t vecs [6];

    initial begin
        //          wb         alu       dest  har hmem rd clr stl  e_wb       e_res     e_dest e_har e_hmem
        vecs[0] = '{23'h12345, 16'h1234, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h12345, 16'h1234, 4'd5, 1'b1, 1'b0};
        vecs[1] = '{23'h7FFFFF, 16'hFFFF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h7FFFFF, 16'hFFFF, 4'hF, 1'b0, 1'b1};
        vecs[2] = '{23'h00111, 16'h4321, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 23'h7FFFFF, 16'hFFFF, 4'hF, 1'b0, 1'b1};
        vecs[3] = '{23'h00001, 16'h0001, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 23'h0,       16'h0000, 4'd0, 1'b0, 1'b0};
        vecs[4] = '{23'h5A5A5, 16'h8000, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 23'h5A5A5,  16'h8000, 4'hA, 1'b1, 1'b1};
        vecs[5] = '{23'h00777, 16'h0040, 4'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 23'h0,       16'h0000, 4'd0, 1'b0, 1'b0};

        rst = 1'b0;
        wb = '0; alu_result = '0; store_data = '0; dest_addr = '0;
        hazard_ar = 0; hazard_mem = 0; memread = 0; memwrite = 0; clear = 0; stall_in = 0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = '0;

        // reset state
        #12;
        chk("rst_stall_out", 32'(stall_out), 32'h0);
        chk("rst_mem_req",   32'(mem_bus.mem_req), 32'h0);
        chk("rst_resultreg", 32'(resultreg), 32'h0);
        chk("rst_wbreg",     32'(wbreg), 32'h0);
        chk("rst_timeout",   32'(mem_timeout), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // non-memory captures, stall_in hold and clear bubbles
        for (int i = 0; i < 6; i++) begin
            wb = vecs[i].wb; alu_result = vecs[i].alu; dest_addr = vecs[i].dest;
            hazard_ar = vecs[i].har; hazard_mem = vecs[i].hmem;
            memread = vecs[i].rd; clear = vecs[i].clr; stall_in = vecs[i].stl;
            tick();
            chk($sformatf("v%0d_result", i), 32'(resultreg), 32'(vecs[i].e_res));
            chk($sformatf("v%0d_dest", i),   32'(destreg),   32'(vecs[i].e_dest));
            chk($sformatf("v%0d_wb", i),     32'(wbreg),     32'(vecs[i].e_wb));
            chk($sformatf("v%0d_haz", i),    32'({hazard_arreg, hazard_memreg}),
                32'({vecs[i].e_har, vecs[i].e_hmem}));
            chk($sformatf("v%0d_stall", i),  32'(stall_out), 32'h0);
        end
        stall_in = 0; clear = 0; memread = 0; hazard_ar = 0; hazard_mem = 0;

        // load, ack in the first ACCESS cycle
        memread = 1; alu_result = 16'h0040; dest_addr = 4'd2; wb = 23'h00ABC;
        tick();
        chk("ld_req",   32'(mem_bus.mem_req), 32'h1);
        chk("ld_stall", 32'(stall_out), 32'h1);
        chk("ld_we",    32'(mem_bus.mem_we), 32'h0);
        chk("ld_addr",  32'(mem_bus.mem_addr), 32'h0040);
        alu_result = 16'h7777; memread = 0;
        mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'hBEEF;
        tick();
        mem_bus.mem_ack = 0; mem_bus.mem_rdata = '0;
        chk("ld_done_req",   32'(mem_bus.mem_req), 32'h0);
        chk("ld_done_stall", 32'(stall_out), 32'h0);
        chk("ld_result",     32'(resultreg), 32'hBEEF);
        chk("ld_dest",       32'(destreg), 32'h2);
        chk("ld_wb",         32'(wbreg), 32'h00ABC);

        // store, ack in the 4th ACCESS cycle
        memwrite = 1; store_data = 16'h00AA; alu_result = 16'h0100; dest_addr = 4'd7; wb = 23'h1;
        tick();
        store_data = 16'h5555; memwrite = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("st_c%0d_stall", k), 32'(stall_out), 32'h1);
            chk($sformatf("st_c%0d_bus", k),
                32'({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata[7:0]}),
                32'({1'b1, 1'b1, 16'h0100, 8'hAA}));
            if (k == 3) mem_bus.mem_ack = 1;
            tick();
        end
        mem_bus.mem_ack = 0;
        chk("st_done_stall", 32'(stall_out), 32'h0);
        chk("st_timeout",    32'(mem_timeout), 32'h0);
        chk("st_result",     32'(resultreg), 32'h0100);
        chk("st_wb",         32'(wbreg), 32'h1);

        // load that never gets an ack
        memread = 1; alu_result = 16'h0200; dest_addr = 4'd9; wb = 23'h3FF;
        tick();
        memread = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("to_c%0d_stall", k), 32'(stall_out), 32'h1);
            chk($sformatf("to_c%0d_pulse", k), 32'(mem_timeout), 32'h0);
            tick();
        end
        chk("to_done_stall", 32'(stall_out), 32'h0);
        chk("to_pulse",      32'(mem_timeout), 32'h1);
        chk("to_wb",         32'(wbreg), 32'h0);
        chk("to_result",     32'(resultreg), 32'hFFFF);
        chk("to_dest",       32'(destreg), 32'h9);
        stall_in = 1;
        tick();
        chk("to_hold_pulse",  32'(mem_timeout), 32'h0);
        chk("to_hold_result", 32'(resultreg), 32'hFFFF);
        chk("to_hold_stall",  32'(stall_out), 32'h0);
        stall_in = 0;

        // read+write treated as read; clear ignored while ACCESS
        memread = 1; memwrite = 1; alu_result = 16'h0300; store_data = 16'h0055;
        dest_addr = 4'd4; wb = 23'h22;
        tick();
        chk("rw_we", 32'(mem_bus.mem_we), 32'h0);
        clear = 1;
        tick();
        chk("clr_acc_stall", 32'(stall_out), 32'h1);
        chk("clr_acc_dest",  32'(destreg), 32'h4);
        mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'h1111;
        tick();
        mem_bus.mem_ack = 0; mem_bus.mem_rdata = '0;
        chk("clr_done_result", 32'(resultreg), 32'h1111);
        chk("clr_done_wb",     32'(wbreg), 32'h22);
        tick();
        chk("clr_bubble", 32'({wbreg, destreg, resultreg}), 32'h0);
        chk("clr_bubble_stall", 32'(stall_out), 32'h0);
        tick();
        chk("clr_idle_req", 32'(mem_bus.mem_req), 32'h0);
        clear = 0; memwrite = 0;

        // asynchronous reset mid-ACCESS
        memread = 1; alu_result = 16'h0400; dest_addr = 4'd8; wb = 23'h44;
        tick();
        chk("ar_req_before", 32'(mem_bus.mem_req), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("ar_req",    32'(mem_bus.mem_req), 32'h0);
        chk("ar_stall",  32'(stall_out), 32'h0);
        chk("ar_result", 32'(resultreg), 32'h0);
        chk("ar_dest",   32'(destreg), 32'h0);
        memread = 0; alu_result = '0; dest_addr = '0; wb = '0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'hDEAD;
        tick();
        mem_bus.mem_ack = 0; mem_bus.mem_rdata = '0;
        chk("ar_late_ack_result", 32'(resultreg), 32'h0);
        chk("ar_late_ack_stall",  32'(stall_out), 32'h0);
        chk("ar_late_ack_req",    32'(mem_bus.mem_req), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
